// File: rtl/bus_transceiver_arbiter_if.sv
// Bus bundle for bus_transceiver_arbiter: per-channel requests, priorities and data in,
// one arbitrated registered word out.
interface bus_transceiver_arbiter_if #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 4
) ();
  logic                      flowvalve;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS-1:0]       prio;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic                      dvalid;
  logic [CHANNELS-1:0]       grant;
  logic                      conflict;

  modport master (
    output flowvalve, req, prio, din,
    input  dout, dvalid, grant, conflict
  );

  modport slave (
    input  flowvalve, req, prio, din,
    output dout, dvalid, grant, conflict
  );
endinterface

// File: rtl/bus_transceiver_arbiter.sv
// Multiplexes CHANNELS source buses onto one registered bus using a priority-aware
// round-robin arbiter with bounded hold time, a global flowvalve gate and conflict flag.
module bus_transceiver_arbiter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAXHOLD  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  bus_transceiver_arbiter_if.slave        bus_io
);
  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned HcW  = $clog2(MAXHOLD + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [HcW-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             conflict_q, conflict_d;

  logic [CHANNELS-1:0] cand, owner_oh;
  logic [IdxW-1:0]     next_ptr;
  logic [IdxW:0]       idle_pick, pre_pick;
  logic                preempt;

  // Returns {found, index} of the first set bit of mask scanning start, start+1, ... mod CHANNELS.
  function automatic logic [IdxW:0] pick(input logic [CHANNELS-1:0] mask,
                                         input logic [IdxW-1:0]     start);
    logic [IdxW:0] res;
    int            j;
    res = '0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      j = (int'(start) + k) % int'(CHANNELS);
      if (mask[IdxW'(j)]) res = {1'b1, IdxW'(j)};
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] word(input logic [CHANNELS*WIDTH-1:0] data,
                                            input logic [IdxW-1:0]           idx);
    return data[idx*WIDTH +: WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    cand      = ((bus_io.req & bus_io.prio) != '0) ? (bus_io.req & bus_io.prio) : bus_io.req;
    next_ptr  = (owner_q == IdxW'(CHANNELS - 1)) ? '0 : owner_q + 1'b1;
    idle_pick = pick(cand, ptr_q);
    pre_pick  = pick(cand & ~owner_oh, next_ptr);
    // A low-class owner yields to any high-class request; an expired hold yields to its class.
    preempt   = (!bus_io.prio[owner_q] && ((bus_io.req & bus_io.prio & ~owner_oh) != '0)) ||
                ((hold_q == HcW'(MAXHOLD)) && ((cand & ~owner_oh) != '0));

    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    conflict_d = ($countones(bus_io.req) > 1);

    unique case (state_q)
      StIdle: begin
        if (bus_io.flowvalve && (bus_io.req != '0)) begin
          state_d  = StOwn;
          owner_d  = idle_pick[IdxW-1:0];
          dout_d   = word(bus_io.din, idle_pick[IdxW-1:0]);
          dvalid_d = 1'b1;
          hold_d   = HcW'(1);
        end
      end
      StOwn: begin
        if (!bus_io.flowvalve) begin
          dvalid_d = 1'b0;
        end else if (!bus_io.req[owner_q]) begin
          state_d = StIdle;
          ptr_d   = next_ptr;
        end else if (preempt) begin
          ptr_d    = next_ptr;
          owner_d  = pre_pick[IdxW-1:0];
          dout_d   = word(bus_io.din, pre_pick[IdxW-1:0]);
          dvalid_d = 1'b1;
          hold_d   = HcW'(1);
        end else begin
          dout_d   = word(bus_io.din, owner_q);
          dvalid_d = 1'b1;
          if (hold_q != HcW'(MAXHOLD)) hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.dout     = dout_q;
    bus_io.dvalid   = dvalid_q;
    bus_io.conflict = conflict_q;
    bus_io.grant    = (state_q == StOwn) ? owner_oh : '0;
  end
endmodule
